painterengine_gpu_fill_source: RTL
==================================

# painterengine_gpu_fill_source

Upstream producer for the GPU DMA writer: fills a rectangle of 32-bit pixels in memory with a constant colour. Splits the rectangle into one writer job per row, drives the writer's router/address/length/data inputs on a fixed channel, streams the colour words through the writer's valid/next handshake, and re-arms the writer between rows by pulsing its reset. Reports busy, done and error to the GPU control registers.

## Interface
- PARAM_CHANNEL, 0: writer channel used (0..3); selects the router bit and the 32-bit lane.
- PARAM_TIMEOUT, 65535: cycles without progress before a timeout error.
- i_wire_clock  in  1  clock.
- i_wire_resetn  in  1  reset; asynchronous, active-low.
- i_wire_start  in  1  start pulse; sampled in IDLE, DONE and ERROR.
- i_wire_base_address  in  32  byte address of the top-left pixel; must be 4-byte aligned.
- i_wire_stride  in  32  byte distance between rows; must be 4-byte aligned.
- i_wire_width  in  16  pixels per row, nonzero.
- i_wire_height  in  16  rows, nonzero.
- i_wire_color  in  32  fill word.
- o_wire_busy  out  1  job in progress.
- o_wire_done  out  1  level; job completed.
- o_wire_error  out  1  level; job aborted.
- o_wire_error_type  out  3  001 param, 010 writer error, 011 timeout, 100 overrun.
- o_wire_writer_resetn  out  1  writer reset, active-low.
- o_wire_writer_router  out  4  one-hot, bit PARAM_CHANNEL.
- o_wire_writer_address  out  128  row address on lane PARAM_CHANNEL, other lanes 0.
- o_wire_writer_length  out  128  width (zero-extended) on lane PARAM_CHANNEL, other lanes 0.
- o_wire_writer_data  out  128  colour on lane PARAM_CHANNEL, other lanes 0.
- o_wire_writer_data_valid  out  4  valid on bit PARAM_CHANNEL only.
- i_wire_writer_data_next  in  4  word consumed; only bit PARAM_CHANNEL is used.
- i_wire_writer_done  in  1  writer finished its row.
- i_wire_writer_error  in  1  writer aborted.

## Operation
- States: IDLE, CHECK, SETUP, RUN, WAIT, DONE, ERROR.
- IDLE/DONE/ERROR + start: latch all inputs; clear row=0, sent=0, timer=0, error_type=000. Go to CHECK.
- CHECK: if width==0, height==0, base[1:0]!=0 or stride[1:0]!=0, go to ERROR with type 001. Otherwise row_addr=base and go to SETUP.
- SETUP: writer_resetn=0 for exactly 2 cycles. Router, address and length are driven and stable from the first SETUP cycle. Then go to RUN.
- RUN: writer_resetn=1. valid = (sent < width). Each cycle with next[CH]=1 increments sent. When sent reaches width, go to WAIT.
- WAIT: valid=0.
  - writer_done: if row==height-1, go to DONE. Otherwise row+=1, row_addr+=stride (32-bit wrap), sent=0, go to SETUP.
- Writer error in RUN or WAIT: go to ERROR with type 010. Writer error takes priority over done in the same cycle.
- next[CH]=1 in WAIT: go to ERROR with type 100.
- Timer: 16-bit. Cleared on every state change and on next[CH]. Increments in RUN and WAIT. When timer==PARAM_TIMEOUT, go to ERROR with type 011.
- DONE and ERROR are sticky until start or reset. writer_resetn=0 in IDLE, DONE and ERROR.
- Arithmetic: sent and row are 16-bit; row_addr is 32-bit; length = {16'b0, width}.

## Timing
- Reset: every output is 0, including writer_resetn and error_type. State is IDLE.
- Start to first valid: 1 cycle CHECK + 2 cycles SETUP, so valid is high in the 4th cycle after the start edge.
- A word transfers on any cycle with valid=1 and next[CH]=1. Data is the constant colour, so no holding register is needed.
- Row turnaround: 3 cycles from done to valid (WAIT exit, then 2 SETUP cycles).
- busy = state in {CHECK, SETUP, RUN, WAIT}.
- done and error assert in the cycle after the causing event.
- Start while busy is ignored.
- Asynchronous reset mid-job: immediate return to reset values; writer_resetn drops at once.

## Structure
- Shared package: state encodings, error codes (001..100), and the lane-width constant 32.
- Single module, no sub-modules. Lane placement uses indexed part-select [PARAM_CHANNEL*32 +: 32].

## Test plan
- base=0x1000_0000, stride=0x400, width=3, height=2, colour=0xFF00FF00, CH=0, writer model ready always:
  - 6 words transferred.
  - Row addresses are 0x1000_0000 and 0x1000_0400, each with length 3.
  - writer_resetn low for 2 cycles before each row.
  - done=1, busy=0 at the end.
- base=0x1000_0002: error=1, type=001, no valid ever asserted.
- Same job with CH=2 and the model stalling next for 10 cycles mid-row:
  - router=4'b0100 and valid only on bit 2.
  - Row completes and sent==width.
- Writer error raised during WAIT of row 0: error=1, type=010, writer_resetn=0, no second row started.
- PARAM_TIMEOUT=16, model never asserts done: type=011 on the 17th WAIT cycle.
- Reset asserted during RUN:
  - All outputs 0 immediately.
  - A following start of width=1, height=1 completes normally.

Source files
------------

// File: rtl/painterengine_gpu_fill_source_pkg.sv
// Shared types and constants for the rectangle fill source.
package painterengine_gpu_fill_source_pkg;

  localparam int unsigned LANE_W = 32;
  localparam int unsigned NUM_CH = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_SETUP,
    ST_RUN,
    ST_WAIT,
    ST_DONE,
    ST_ERROR
  } fill_state_t;

  typedef enum logic [2:0] {
    ERR_NONE    = 3'b000,
    ERR_PARAM   = 3'b001,
    ERR_WRITER  = 3'b010,
    ERR_TIMEOUT = 3'b011,
    ERR_OVERRUN = 3'b100
  } fill_err_t;

  function automatic logic state_is_busy(input fill_state_t s);
    return (s == ST_CHECK) || (s == ST_SETUP) || (s == ST_RUN) || (s == ST_WAIT);
  endfunction

endpackage

// File: rtl/painterengine_gpu_fill_source.sv
// Rectangle fill producer: one DMA writer job per row, constant colour stream.
module painterengine_gpu_fill_source
  import painterengine_gpu_fill_source_pkg::*;
#(
  parameter int unsigned PARAM_CHANNEL = 0,
  parameter int unsigned PARAM_TIMEOUT = 65535
) (
  input  logic         i_wire_clock,
  input  logic         i_wire_resetn,
  input  logic         i_wire_start,
  input  logic [31:0]  i_wire_base_address,
  input  logic [31:0]  i_wire_stride,
  input  logic [15:0]  i_wire_width,
  input  logic [15:0]  i_wire_height,
  input  logic [31:0]  i_wire_color,
  output logic         o_wire_busy,
  output logic         o_wire_done,
  output logic         o_wire_error,
  output logic [2:0]   o_wire_error_type,
  output logic         o_wire_writer_resetn,
  output logic [3:0]   o_wire_writer_router,
  output logic [127:0] o_wire_writer_address,
  output logic [127:0] o_wire_writer_length,
  output logic [127:0] o_wire_writer_data,
  output logic [3:0]   o_wire_writer_data_valid,
  input  logic [3:0]   i_wire_writer_data_next,
  input  logic         i_wire_writer_done,
  input  logic         i_wire_writer_error
);

  localparam logic [NUM_CH-1:0] CH_MASK = NUM_CH'(1) << PARAM_CHANNEL;
  localparam logic [15:0]       TIMEOUT = 16'(PARAM_TIMEOUT);

  fill_state_t state, state_nxt;
  fill_err_t   err_q, err_nxt;

  logic [31:0] base_q, stride_q, color_q, row_addr_q;
  logic [15:0] width_q, height_q, row_q, sent_q, timer_q;
  logic        setup_second_q;
  logic        next_ch;
  logic        do_latch, do_addr_init, do_row_adv, do_sent_inc;

  // Masking with the channel bit keeps the other lanes' next bits inert.
  assign next_ch = |(i_wire_writer_data_next & CH_MASK);

  // State register.
  always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
    if (!i_wire_resetn) state <= ST_IDLE;
    else                state <= state_nxt;
  end

  // Next-state, error code and datapath strobes.
  always_comb begin
    state_nxt    = state;
    err_nxt      = err_q;
    do_latch     = 1'b0;
    do_addr_init = 1'b0;
    do_row_adv   = 1'b0;
    do_sent_inc  = 1'b0;
    case (state)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (i_wire_start) begin
          state_nxt = ST_CHECK;
          err_nxt   = ERR_NONE;
          do_latch  = 1'b1;
        end
      end
      ST_CHECK: begin
        if (width_q == '0 || height_q == '0 || base_q[1:0] != 2'b00 || stride_q[1:0] != 2'b00) begin
          state_nxt = ST_ERROR;
          err_nxt   = ERR_PARAM;
        end else begin
          state_nxt    = ST_SETUP;
          do_addr_init = 1'b1;
        end
      end
      ST_SETUP: begin
        if (setup_second_q) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (i_wire_writer_error) begin
          state_nxt = ST_ERROR;
          err_nxt   = ERR_WRITER;
        end else if (timer_q == TIMEOUT) begin
          state_nxt = ST_ERROR;
          err_nxt   = ERR_TIMEOUT;
        end else if (next_ch) begin
          do_sent_inc = 1'b1;
          if (16'(sent_q + 16'd1) == width_q) state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (i_wire_writer_error) begin
          state_nxt = ST_ERROR;
          err_nxt   = ERR_WRITER;
        end else if (next_ch) begin
          state_nxt = ST_ERROR;
          err_nxt   = ERR_OVERRUN;
        end else if (timer_q == TIMEOUT) begin
          state_nxt = ST_ERROR;
          err_nxt   = ERR_TIMEOUT;
        end else if (i_wire_writer_done) begin
          if (row_q == 16'(height_q - 16'd1)) begin
            state_nxt = ST_DONE;
          end else begin
            state_nxt  = ST_SETUP;
            do_row_adv = 1'b1;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Job registers, row/word counters and progress timer.
  always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
    if (!i_wire_resetn) begin
      base_q         <= '0;
      stride_q       <= '0;
      color_q        <= '0;
      width_q        <= '0;
      height_q       <= '0;
      row_addr_q     <= '0;
      row_q          <= '0;
      sent_q         <= '0;
      timer_q        <= '0;
      setup_second_q <= 1'b0;
      err_q          <= ERR_NONE;
    end else begin
      err_q          <= err_nxt;
      setup_second_q <= (state == ST_SETUP) && !setup_second_q;
      if (do_latch) begin
        base_q   <= i_wire_base_address;
        stride_q <= i_wire_stride;
        color_q  <= i_wire_color;
        width_q  <= i_wire_width;
        height_q <= i_wire_height;
        row_q    <= '0;
        sent_q   <= '0;
      end
      if (do_addr_init) row_addr_q <= base_q;
      if (do_row_adv) begin
        row_q      <= row_q + 16'd1;
        row_addr_q <= row_addr_q + stride_q;
        sent_q     <= '0;
      end
      if (do_sent_inc) sent_q <= sent_q + 16'd1;
      if (state_nxt != state || next_ch) timer_q <= '0;
      else if (state == ST_RUN || state == ST_WAIT) timer_q <= timer_q + 16'd1;
    end
  end

  // Status and writer-side outputs, decoded from state so reset clears them at once.
  always_comb begin
    o_wire_busy              = state_is_busy(state);
    o_wire_done              = (state == ST_DONE);
    o_wire_error             = (state == ST_ERROR);
    o_wire_error_type        = err_q;
    o_wire_writer_resetn     = (state == ST_RUN) || (state == ST_WAIT);
    o_wire_writer_router     = '0;
    o_wire_writer_address    = '0;
    o_wire_writer_length     = '0;
    o_wire_writer_data       = '0;
    o_wire_writer_data_valid = '0;
    if (state == ST_SETUP || state == ST_RUN || state == ST_WAIT) begin
      o_wire_writer_router = CH_MASK;
      o_wire_writer_address[PARAM_CHANNEL*LANE_W +: LANE_W] = row_addr_q;
      o_wire_writer_length[PARAM_CHANNEL*LANE_W +: LANE_W]  = {16'b0, width_q};
      o_wire_writer_data[PARAM_CHANNEL*LANE_W +: LANE_W]    = color_q;
    end
    if (state == ST_RUN && sent_q < width_q) o_wire_writer_data_valid = CH_MASK;
  end

endmodule
